ahb_data_responder: RTL and testbench

Single-port 64-bit data memory acting as the responder on the load/store bus driven by the pipeline's memory-access stage. It accepts one transfer per address phase, inserts a configurable number of wait states, and completes reads with `HRDATA` and writes by committing `HWDATA` to its array. Illegal transfers (out of range or misaligned) get a two-cycle error response. Sits between the core's bus port and on-chip RAM; a single instance serves the whole data address window.

---
 rtl/ahb_data_responder_pkg.sv | 23 ++
 rtl/ahb_data_responder_if.sv | 23 ++
 rtl/ahb_data_responder_ram.sv | 27 ++
 rtl/ahb_data_responder.sv | 120 ++++++++++++
 tb/tb_ahb_data_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_data_responder_pkg.sv
// Shared bus definitions for the data-side load/store bus: transfer and
// response codes, responder state encoding and the bus word type.
package bus_pkg;

  localparam int WORD_W = 64;

  localparam logic HTRANS_IDLE = 1'b0;
  localparam logic HTRANS_BUSY = 1'b1;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

endpackage

// File: rtl/ahb_data_responder_if.sv
// Load/store bus between the memory-access stage (master) and the data
// memory responder (slave).
interface ahb_data_responder_if;

  bus_pkg::word_t HADDR;
  logic           HWRITE;
  logic           HTRANS;
  bus_pkg::word_t HWDATA;
  bus_pkg::word_t HRDATA;
  logic           HREADY;
  logic           HRESP;

  modport master (
    output HADDR, HWRITE, HTRANS, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HTRANS, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb_data_responder_ram.sv
// Word-wide storage for the data responder: one synchronous write port and
// one asynchronous read port sharing a single index. Contents survive reset.
module data_ram_array
  import bus_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  word_t            wdata,
  output word_t            rdata
);

  word_t mem [DEPTH_WORDS];

  // Commit a write at the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_data_responder.sv
// Data memory responder: accepts one transfer per address phase, inserts
// WAIT_STATES ready-low cycles on legal transfers, answers illegal ones with
// a two-cycle ERROR, and commits writes at the end of the completion cycle.
module ahb_data_responder
  import bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          WAIT_STATES = 0
) (
  input logic                 CLK,
  input logic                 RST,
  ahb_data_responder_if.slave bus
);

  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_t           state;
  state_t           nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_write;
  logic             hready_q;
  logic             hresp_q;

  logic             accept;
  logic             legal;
  logic             below_base;
  logic [63:0]      offset;
  logic [IDX_W-1:0] addr_idx;
  word_t            ram_rdata;
  logic             ram_we;

  // Ready is high whenever the bus can take a new address phase.
  function automatic logic ready_of(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR2);
  endfunction

  function automatic logic resp_of(input state_t s);
    return ((s == ST_ERR1) || (s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  endfunction

  // The borrow of the 65-bit subtraction flags addresses below the window;
  // the window is aligned to its size, so the upper offset bits must be zero.
  assign {below_base, offset} = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
  assign legal    = (bus.HADDR[2:0] == 3'd0) && !below_base &&
                    (offset[63:IDX_W+3] == '0);
  assign addr_idx = offset[IDX_W+2:3];
  assign accept   = (bus.HTRANS == HTRANS_BUSY) && hready_q;

  // Next state and wait counter; a new transfer can only start when ready.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      ST_WAIT: begin
        if (cnt == 4'd1) begin
          nxt     = ST_DONE;
          cnt_nxt = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ERR1: nxt = ST_ERR2;
      default: begin
        nxt = ST_IDLE;
        if (accept) begin
          if (!legal) begin
            nxt = ST_ERR1;
          end else if (WS != 4'd0) begin
            nxt     = ST_WAIT;
            cnt_nxt = WS;
          end else begin
            nxt = ST_DONE;
          end
        end
      end
    endcase
  end

  // Responder FSM with registered ready/response and the pending transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      pend_write <= 1'b0;
      hready_q   <= 1'b1;
      hresp_q    <= HRESP_OKAY;
    end else begin
      state    <= nxt;
      cnt      <= cnt_nxt;
      hready_q <= ready_of(nxt);
      hresp_q  <= resp_of(nxt);
      if (accept) begin
        pend_write <= bus.HWRITE && legal;
        pend_idx   <= addr_idx;
      end
    end
  end

  // A reset coinciding with the completion cycle drops the write.
  assign ram_we = (state == ST_DONE) && pend_write && !RST;

  data_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .idx  (pend_idx),
    .wdata(bus.HWDATA),
    .rdata(ram_rdata)
  );

  assign bus.HRDATA = ((state == ST_DONE) && !pend_write) ? ram_rdata : '0;
  assign bus.HREADY = hready_q;
  assign bus.HRESP  = hresp_q;

endmodule

// File: tb/tb_ahb_data_responder.sv
// Directed bench for the data memory responder: three instances with
// different wait-state counts, windows and depths, plus a mixed sweep
// checked against a reference word model.
module tb_ahb_data_responder;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_data_responder_if b0 ();
  ahb_data_responder_if b1 ();
  ahb_data_responder_if b2 ();

  ahb_data_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(64'h0), .WAIT_STATES(0))
    dut0 (.CLK(clk), .RST(rst), .bus(b0));
  ahb_data_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(64'h8000), .WAIT_STATES(3))
    dut1 (.CLK(clk), .RST(rst), .bus(b1));
  ahb_data_responder #(.DEPTH_WORDS(16), .BASE_ADDR(64'h0), .WAIT_STATES(7))
    dut2 (.CLK(clk), .RST(rst), .bus(b2));

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] model [3][16];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] base_of(input int s);
    return (s == 1) ? 64'h8000 : 64'h0;
  endfunction

  function automatic int depth_of(input int s);
    return (s == 2) ? 16 : 1024;
  endfunction

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 3 : 7);
  endfunction

  function automatic logic [63:0] pre_val(input int s, input int w);
    return 64'hA5A5_0000_0000_0000 | (64'(s) << 16) | 64'(w);
  endfunction

  task automatic drive(input int s, input logic t, input logic w,
                       input logic [63:0] a, input logic [63:0] d);
    case (s)
      0: begin b0.HTRANS = t; b0.HWRITE = w; b0.HADDR = a; b0.HWDATA = d; end
      1: begin b1.HTRANS = t; b1.HWRITE = w; b1.HADDR = a; b1.HWDATA = d; end
      default: begin b2.HTRANS = t; b2.HWRITE = w; b2.HADDR = a; b2.HWDATA = d; end
    endcase
  endtask

  function automatic logic rdy(input int s);
    return (s == 0) ? b0.HREADY : ((s == 1) ? b1.HREADY : b2.HREADY);
  endfunction

  function automatic logic resp(input int s);
    return (s == 0) ? b0.HRESP : ((s == 1) ? b1.HRESP : b2.HRESP);
  endfunction

  function automatic logic [63:0] rdat(input int s);
    return (s == 0) ? b0.HRDATA : ((s == 1) ? b1.HRDATA : b2.HRDATA);
  endfunction

  // Called at a falling edge inside a data phase; returns at the ready cycle.
  task automatic wait_ready(input int s, output int low);
    int n;
    n   = 0;
    low = 0;
    while (!rdy(s) && n < 40) begin
      low++;
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk_eq($sformatf("s%0d_ready_timeout", s), 64'(rdy(s)), 64'd1);
  endtask

  task automatic do_xfer(input int s, input logic w, input logic [63:0] a,
                         input logic [63:0] d, output logic [63:0] rd,
                         output logic er, output int low);
    @(negedge clk);
    drive(s, 1'b1, w, a, 64'h0);
    @(negedge clk);
    drive(s, 1'b0, 1'b0, 64'h0, d);
    wait_ready(s, low);
    rd = rdat(s);
    er = resp(s);
  endtask

  task automatic xfer_chk(input int s, input logic w, input logic [63:0] a,
                          input logic [63:0] d);
    logic [63:0] rd;
    logic [63:0] off;
    logic        er;
    logic        ill;
    int          low;
    int          wi;
    off = a - base_of(s);
    ill = (a[2:0] != 3'd0) || (a < base_of(s)) || (off >= 64'(depth_of(s)) * 64'd8);
    wi  = int'(off[6:3]);
    do_xfer(s, w, a, d, rd, er, low);
    chk_eq($sformatf("s%0d_resp@%h", s, a), 64'(er), 64'(ill));
    chk_eq($sformatf("s%0d_lowcnt@%h", s, a), 64'(low), ill ? 64'd1 : 64'(ws_of(s)));
    if (!ill && w) model[s][wi] = d;
    chk_eq($sformatf("s%0d_rdata@%h", s, a), rd, (!ill && !w) ? model[s][wi] : 64'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          low;
    int          kind;
    int          wi;
    logic        w;
    logic [63:0] a;
    logic [63:0] d;

    rst = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk_eq($sformatf("s%0d_rst_hready", s), 64'(rdy(s)), 64'd1);
      chk_eq($sformatf("s%0d_rst_hresp", s), 64'(resp(s)), 64'd0);
      chk_eq($sformatf("s%0d_rst_hrdata", s), rdat(s), 64'h0);
    end
    rst = 1'b0;

    // Preload the first 16 words of every instance.
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 16; k++)
        xfer_chk(s, 1'b1, base_of(s) + 64'(k) * 64'd8, pre_val(s, k));

    // Zero wait states: write 0x18 then read it in the very next address phase.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 64'h18, 64'h0);
    @(negedge clk);
    chk_eq("wr_done_hready", 64'(rdy(0)), 64'd1);
    chk_eq("wr_done_hrdata", rdat(0), 64'h0);
    drive(0, 1'b1, 1'b0, 64'h18, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    chk_eq("rd_done_hready", 64'(rdy(0)), 64'd1);
    chk_eq("rd_done_hresp", 64'(resp(0)), 64'd0);
    chk_eq("rd_after_wr", rdat(0), 64'hDEAD_BEEF_0123_4567);
    drive(0, 1'b0, 1'b0, 64'h0, 64'h0);
    model[0][3] = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    chk_eq("idle_hready", 64'(rdy(0)), 64'd1);
    chk_eq("idle_hrdata", rdat(0), 64'h0);

    // Back-to-back reads of words 0, 1, 2.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 64'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_eq($sformatf("b2b_hready%0d", k), 64'(rdy(0)), 64'd1);
      chk_eq($sformatf("b2b_hrdata%0d", k), rdat(0), pre_val(0, k));
      if (k < 2) drive(0, 1'b1, 1'b0, 64'(k + 1) * 64'd8, 64'h0);
      else drive(0, 1'b0, 1'b0, 64'h0, 64'h0);
    end

    // Three wait states with HTRANS held high through the wait.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 64'h8040, 64'h0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 64'h8048, 64'h0);
    wait_ready(1, low);
    chk_eq("ws3_low_first", 64'(low), 64'd3);
    chk_eq("ws3_rdata_first", rdat(1), pre_val(1, 8));
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 64'h0, 64'h0);
    wait_ready(1, low);
    chk_eq("ws3_low_second", 64'(low), 64'd3);
    chk_eq("ws3_rdata_second", rdat(1), pre_val(1, 9));

    // Misaligned read: ERR1 then ERR2 regardless of wait states.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 64'h801C, 64'h0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 64'h0, 64'h0);
    chk_eq("err1_hready", 64'(rdy(1)), 64'd0);
    chk_eq("err1_hresp", 64'(resp(1)), 64'd1);
    @(negedge clk);
    chk_eq("err2_hready", 64'(rdy(1)), 64'd1);
    chk_eq("err2_hresp", 64'(resp(1)), 64'd1);
    chk_eq("err2_hrdata", rdat(1), 64'h0);
    @(negedge clk);
    chk_eq("post_err_hresp", 64'(resp(1)), 64'd0);

    // Illegal writes leave the array untouched.
    xfer_chk(1, 1'b1, 64'h8000 + 64'h2000, 64'h0BAD_0BAD_0BAD_0BAD);
    xfer_chk(1, 1'b1, 64'h8044, 64'h0BAD_0BAD_0BAD_0BAD);
    xfer_chk(1, 1'b0, 64'h7FF8, 64'h0);
    xfer_chk(1, 1'b0, 64'h8000, 64'h0);
    xfer_chk(1, 1'b0, 64'h8040, 64'h0);
    xfer_chk(2, 1'b1, 64'h80, 64'h0BAD_0BAD_0BAD_0BAD);
    xfer_chk(2, 1'b0, 64'h0, 64'h0);

    // Reset pulsed during the completion cycle of a write drops it.
    xfer_chk(0, 1'b1, 64'h20, 64'h5);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 64'h20, 64'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 64'h0, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rst_done_hready", 64'(rdy(0)), 64'd1);
    chk_eq("rst_done_hresp", 64'(resp(0)), 64'd0);
    chk_eq("rst_done_hrdata", rdat(0), 64'h0);
    xfer_chk(0, 1'b0, 64'h20, 64'h0);
    chk_eq("rst_drop_model", model[0][4], 64'h5);

    // Mixed legal and illegal transfers against the word model.
    for (int i = 0; i < 300; i++) begin
      for (int s = 0; s < 3; s++) begin
        kind = int'($urandom_range(0, 7));
        w    = 1'($urandom_range(0, 1));
        wi   = int'($urandom_range(0, 15));
        d    = {$urandom, $urandom};
        a    = base_of(s) + 64'(wi) * 64'd8;
        if (kind == 6) a = a + 64'($urandom_range(1, 7));
        else if (kind == 7) begin
          if (s == 1 && wi[0]) a = base_of(s) - 64'(wi + 1) * 64'd8;
          else a = base_of(s) + 64'(depth_of(s)) * 64'd8 + 64'(wi) * 64'd8;
        end
        xfer_chk(s, w, a, d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
